// File: rtl/conv_window_gen.sv
// conv_window_gen: 3x3 window generator and phase counters feeding the
// convolution control FSM.
//   clk, rst_n       - clock, asynchronous active-low reset
//   in_valid/in_data - gapless raster pixel stream
//   state            - control FSM state (00 preload, 01 output, 10 skip, 11 illegal)
//   count_data/line/skip - phase counters consumed by the FSM
//   win_valid/win_data   - registered 3x3 window, w0 in the LSBs
//   frame_done       - one-cycle pulse after the last pixel of the frame
//   frame_err        - sticky flag for a gap inside the frame
module conv_window_gen #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned IMG_W    = 14,
    parameter int unsigned IMG_H    = 14,
    parameter int unsigned PRELOAD  = 32,
    parameter int unsigned LINE_OUT = 12,
    parameter int unsigned SKIP     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [1:0]          state,
    output logic [7:0]          count_data,
    output logic [3:0]          count_line,
    output logic [1:0]          count_skip,
    output logic                win_valid,
    output logic [9*DATA_W-1:0] win_data,
    output logic                frame_done,
    output logic                frame_err
);
    localparam int unsigned DEPTH  = 2*IMG_W + 3;
    localparam int unsigned NPIX   = IMG_W * IMG_H;
    localparam int unsigned PCNT_W = $clog2(NPIX + 1);

    localparam logic [7:0]        DATA_LAST = 8'(PRELOAD - 1);
    localparam logic [3:0]        LINE_LAST = 4'(LINE_OUT - 1);
    localparam logic [1:0]        SKIP_LAST = 2'(SKIP - 1);
    localparam logic [PCNT_W-1:0] PIX_END   = PCNT_W'(NPIX);
    localparam logic [PCNT_W-1:0] PIX_LAST  = PCNT_W'(NPIX - 1);

    typedef enum logic [1:0] {
        ST_PRELOAD = 2'b00,
        ST_OUTPUT  = 2'b01,
        ST_SKIP    = 2'b10,
        ST_ILLEGAL = 2'b11
    } fsm_state_e;

    fsm_state_e fsm_st;

    logic [DATA_W-1:0]   dl_q [DEPTH];
    logic [DATA_W-1:0]   dl_d [DEPTH];
    logic [7:0]          cnt_data_q, cnt_data_d;
    logic [3:0]          cnt_line_q, cnt_line_d;
    logic [1:0]          cnt_skip_q, cnt_skip_d;
    logic [PCNT_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic                win_valid_q, win_valid_d;
    logic [9*DATA_W-1:0] win_data_q, win_data_d;
    logic                frame_done_q, frame_done_d;
    logic                frame_err_q, frame_err_d;
    logic                frame_over;
    logic                accept;

    assign fsm_st     = fsm_state_e'(state);
    assign frame_over = (pix_cnt_q == PIX_END);
    assign accept     = in_valid && !frame_over;

    // Next-state logic: shift, counters, window capture, frame tracking.
    always_comb begin
        dl_d         = dl_q;
        cnt_data_d   = cnt_data_q;
        cnt_line_d   = cnt_line_q;
        cnt_skip_d   = cnt_skip_q;
        pix_cnt_d    = pix_cnt_q;
        win_valid_d  = 1'b0;
        win_data_d   = win_data_q;
        frame_done_d = 1'b0;
        frame_err_d  = frame_err_q;

        // A gap only counts once the frame has started and before it ends.
        if (!in_valid && (pix_cnt_q != '0) && !frame_over) begin
            frame_err_d = 1'b1;
        end

        if (accept) begin
            dl_d[0] = in_data;
            for (int i = 1; i < DEPTH; i++) begin
                dl_d[i] = dl_q[i-1];
            end
            pix_cnt_d    = pix_cnt_q + PCNT_W'(1);
            frame_done_d = (pix_cnt_q == PIX_LAST);

            case (fsm_st)
                ST_PRELOAD: begin
                    if (cnt_data_q != DATA_LAST) begin
                        cnt_data_d = cnt_data_q + 8'd1;
                    end
                end
                ST_OUTPUT: begin
                    cnt_line_d  = (cnt_line_q == LINE_LAST) ? 4'd0 : cnt_line_q + 4'd1;
                    win_valid_d = 1'b1;
                    // Taps taken from the post-shift line so w0 is this pixel.
                    win_data_d  = {dl_d[2*IMG_W+2], dl_d[2*IMG_W+1], dl_d[2*IMG_W],
                                   dl_d[IMG_W+2],   dl_d[IMG_W+1],   dl_d[IMG_W],
                                   dl_d[2],         dl_d[1],         dl_d[0]};
                end
                ST_SKIP: begin
                    cnt_skip_d = (cnt_skip_q == SKIP_LAST) ? 2'd0 : cnt_skip_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                dl_q[i] <= '0;
            end
            cnt_data_q   <= '0;
            cnt_line_q   <= '0;
            cnt_skip_q   <= '0;
            pix_cnt_q    <= '0;
            win_valid_q  <= 1'b0;
            win_data_q   <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            dl_q         <= dl_d;
            cnt_data_q   <= cnt_data_d;
            cnt_line_q   <= cnt_line_d;
            cnt_skip_q   <= cnt_skip_d;
            pix_cnt_q    <= pix_cnt_d;
            win_valid_q  <= win_valid_d;
            win_data_q   <= win_data_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign count_data = cnt_data_q;
    assign count_line = cnt_line_q;
    assign count_skip = cnt_skip_q;
    assign win_valid  = win_valid_q;
    assign win_data   = win_data_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: scoreboard bench for conv_window_gen with a
// behavioural control FSM and a pixel-history window model.
`timescale 1ns/1ps
module tb_conv_window_gen;
    localparam int DW   = 8;
    localparam int W    = 14;
    localparam int H    = 14;
    localparam int NPIX = W * H;
    localparam int PRE  = 32;
    localparam int LO   = 12;
    localparam int SK   = 2;

    typedef struct packed {
        logic [7:0]      cd;
        logic [3:0]      cl;
        logic [1:0]      cs;
        logic            wv;
        logic [9*DW-1:0] wd;
        logic            fd;
        logic            fe;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic [DW-1:0]   in_data = '0;
    logic [1:0]      state = 2'b00;
    logic [7:0]      count_data;
    logic [3:0]      count_line;
    logic [1:0]      count_skip;
    logic            win_valid;
    logic [9*DW-1:0] win_data;
    logic            frame_done;
    logic            frame_err;

    conv_window_gen #(
        .DATA_W(DW), .IMG_W(W), .IMG_H(H), .PRELOAD(PRE), .LINE_OUT(LO), .SKIP(SK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .state(state), .count_data(count_data), .count_line(count_line),
        .count_skip(count_skip), .win_valid(win_valid), .win_data(win_data),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state
    exp_t            exp_q[$];
    int              hist[NPIX];
    int              m_pix;
    logic [7:0]      m_cd;
    logic [3:0]      m_cl;
    logic [1:0]      m_cs;
    logic [9*DW-1:0] m_win;
    logic            m_err;
    logic [1:0]      f_st;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int px(input int idx);
        return (idx >= 0) ? hist[idx] : 0;
    endfunction

    function automatic logic [9*DW-1:0] taps(input int n);
        int offs[9];
        logic [9*DW-1:0] r;
        offs = '{0, 1, 2, W, W+1, W+2, 2*W, 2*W+1, 2*W+2};
        r = '0;
        for (int k = 0; k < 9; k++) r[k*DW +: DW] = DW'(px(n - offs[k]));
        return r;
    endfunction

    // Compare every queued expectation on the falling edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("count_data", count_data, e.cd);
            check_eq("count_line", count_line, e.cl);
            check_eq("count_skip", count_skip, e.cs);
            check_eq("win_valid",  win_valid,  e.wv);
            check_eq("win_data",   win_data,   e.wd);
            check_eq("frame_done", frame_done, e.fd);
            check_eq("frame_err",  frame_err,  e.fe);
        end
    end

    task automatic model_clear();
        m_pix = 0; m_cd = '0; m_cl = '0; m_cs = '0; m_win = '0; m_err = 1'b0; f_st = 2'b00;
        exp_q.delete();
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_cd"}, count_data, 0);
        check_eq({tag, "_cl"}, count_line, 0);
        check_eq({tag, "_cs"}, count_skip, 0);
        check_eq({tag, "_wv"}, win_valid,  0);
        check_eq({tag, "_wd"}, win_data,   0);
        check_eq({tag, "_fd"}, frame_done, 0);
        check_eq({tag, "_fe"}, frame_err,  0);
    endtask

    // Asynchronous reset mid-cycle, then release on a falling edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0; in_valid = 1'b0;
        model_clear();
        #1;
        check_zero(tag);
        @(negedge clk); #1;
        rst_n = 1'b1;
        #1;
    endtask

    // One clock: drive inputs, advance the model, queue its prediction.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit force_ill);
        exp_t e;
        logic [1:0] st;
        bit acc;
        st = force_ill ? 2'b11 : f_st;
        in_valid = v; in_data = d; state = st;
        acc = v && (m_pix < NPIX);
        e.wv = 1'b0; e.fd = 1'b0;
        if (!v && m_pix > 0 && m_pix < NPIX) m_err = 1'b1;
        if (acc) begin
            hist[m_pix] = int'(d);
            case (st)
                2'b00: begin
                    if (m_cd == 8'(PRE - 1)) f_st = 2'b01;
                    else m_cd = m_cd + 8'd1;
                end
                2'b01: begin
                    e.wv  = 1'b1;
                    m_win = taps(m_pix);
                    if (m_cl == 4'(LO - 1)) begin m_cl = 4'd0; f_st = 2'b10; end
                    else m_cl = m_cl + 4'd1;
                end
                2'b10: begin
                    if (m_cs == 2'(SK - 1)) begin m_cs = 2'd0; f_st = 2'b01; end
                    else m_cs = m_cs + 2'd1;
                end
                default: ;
            endcase
            if (m_pix == NPIX - 1) e.fd = 1'b1;
            m_pix++;
        end
        e.cd = m_cd; e.cl = m_cl; e.cs = m_cs; e.wd = m_win; e.fe = m_err;
        @(posedge clk);
        exp_q.push_back(e);
        @(negedge clk); #1;
    endtask

    // Idle lead-in, n pixels valued by index, optional one-cycle gap, tail burst.
    task automatic run_frame(input int n, input int gap_at, input int tail);
        for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) step(1'b0, '0, 1'b0);
            step(1'b1, DW'(i), 1'b0);
            if (i == 32 && gap_at < 0) begin
                check_eq("first_w0", win_data[0*DW +: DW], 32);
                check_eq("first_w3", win_data[3*DW +: DW], 18);
                check_eq("first_w6", win_data[6*DW +: DW], 4);
                check_eq("first_w8", win_data[8*DW +: DW], 2);
            end
        end
        for (int k = 0; k < tail; k++) step(1'b1, 8'hA5, 1'b0);
        for (int k = 0; k < 2; k++) step(1'b0, '0, 1'b0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < NPIX; i++) hist[i] = 0;
        model_clear();
        #2;
        check_zero("por");
        @(negedge clk); #1;
        rst_n = 1'b1;
        #1;

        // Preload only: state pinned at S0.
        for (int i = 0; i < PRE; i++) begin
            in_valid = 1'b1; in_data = DW'(i); state = 2'b00;
            hist[m_pix] = i; m_pix++;
            if (m_cd != 8'(PRE - 1)) m_cd = m_cd + 8'd1;
            @(posedge clk);
            exp_q.push_back('{cd: m_cd, cl: 4'd0, cs: 2'd0, wv: 1'b0, wd: '0, fd: 1'b0, fe: 1'b0});
            @(negedge clk); #1;
        end
        check_eq("preload_sat", count_data, PRE - 1);
        do_reset("rst1");

        // Full gapless frame plus post-frame burst.
        run_frame(NPIX, -1, 5);
        do_reset("rst2");

        // Frame with a one-cycle gap before pixel 50.
        run_frame(NPIX, 50, 0);
        check_eq("err_sticky", frame_err, 1);
        do_reset("rst3");

        // Reset at pixel 100, then the frame must repeat exactly.
        run_frame(100, -1, 0);
        do_reset("rst_mid");
        run_frame(NPIX, -1, 3);
        do_reset("rst4");

        // Illegal state for three accepted pixels mid-stream.
        for (int i = 0; i < 40; i++) step(1'b1, DW'(i), 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, DW'(200 + k), 1'b1);
        for (int i = 40; i < 60; i++) step(1'b1, DW'(i), 1'b0);

        @(negedge clk); #1;
        check_eq("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
